traffic_safety_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 55 +++++
 rtl/traffic_flash_gen.sv | 45 ++++
 rtl/traffic_safety_monitor.sv | 159 +++++++++++++++
 tb/tb_traffic_safety_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_pkg                                                              |
// | Lamp codes, fault causes, monitor states and code/step legality helpers. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package traffic_pkg;

    typedef logic [2:0] light_t;

    // Lamp codes are {red, amber, green}
    localparam light_t RED       = 3'b100;
    localparam light_t RED_AMBER = 3'b110;
    localparam light_t GREEN     = 3'b001;
    localparam light_t AMBER     = 3'b010;
    localparam light_t DARK      = 3'b000;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        CONFLICT  = 3'd1,
        ILLEGAL_A = 3'd2,
        ILLEGAL_B = 3'd3,
        BAD_CODE  = 3'd4,
        STALL     = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        FAULT   = 2'd2,
        RECOVER = 2'd3
    } mon_state_t;

    function automatic logic is_legal_code(light_t code);
        return (code == RED) || (code == RED_AMBER) ||
               (code == GREEN) || (code == AMBER);
    endfunction

    // Holding is always legal; otherwise only the single forward step is.
    function automatic logic is_legal_step(light_t prev, light_t cur);
        logic ok;
        ok = 1'b0;
        case (prev)
            RED:       ok = (cur == RED)       || (cur == RED_AMBER);
            RED_AMBER: ok = (cur == RED_AMBER) || (cur == GREEN);
            GREEN:     ok = (cur == GREEN)     || (cur == AMBER);
            AMBER:     ok = (cur == AMBER)     || (cur == RED);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_flash_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_flash_gen                                                        |
// | Free-running half-period counter and phase for fault-mode flashing.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module traffic_flash_gen #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_phase
);

    localparam int c_CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(FLASH_HALF - 1);
    // The lamp register samples this phase one edge later, so a restart
    // preloads the count for the first cycle after entry, not the entry cycle.
    localparam logic [c_CW-1:0] c_CNT_START = c_CW'((FLASH_HALF > 1) ? 1 : 0);
    localparam logic            c_PH_START  = (FLASH_HALF == 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_restart) begin
            r_cnt   <= c_CNT_START;
            r_phase <= c_PH_START;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/traffic_safety_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | traffic_safety_monitor                                                   |
// | Guards sequencer lamp codes; forces flashing amber on any violation.     |
// | Optional stall watchdog: define TRAFFIC_MON_WATCHDOG_EN.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module traffic_safety_monitor
    import traffic_pkg::*;
#(
    parameter int FLASH_HALF = 4,
    parameter int STALL_MAX  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [2:0] lights_a_in,
    input  logic [2:0] lights_b_in,
    input  logic       clear_fault,
    output logic [2:0] lights_a_out,
    output logic [2:0] lights_b_out,
    output logic       fault,
    output logic [2:0] fault_code
);

    if (FLASH_HALF < 1 || STALL_MAX < 2) begin : g_param_check
        $error("traffic_safety_monitor: FLASH_HALF must be >= 1 and STALL_MAX >= 2");
    end

    mon_state_t  r_state;
    light_t      r_prev_a;
    light_t      r_prev_b;
    light_t      r_out_a;
    light_t      r_out_b;
    logic        r_fault;
    fault_code_t r_fault_code;

    fault_code_t w_code;
    logic        w_bad;
    logic        w_conflict;
    logic        w_ill_a;
    logic        w_ill_b;
    logic        w_stall;
    logic        w_trip;
    logic        w_phase;

    assign w_bad      = !is_legal_code(lights_a_in) || !is_legal_code(lights_b_in);
    assign w_conflict = (lights_a_in != RED) && (lights_b_in != RED);
    assign w_ill_a    = !is_legal_step(r_prev_a, lights_a_in);
    assign w_ill_b    = !is_legal_step(r_prev_b, lights_b_in);

`ifdef TRAFFIC_MON_WATCHDOG_EN
    localparam int c_SW = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;
    localparam logic [c_SW-1:0] c_STALL_LAST = c_SW'(STALL_MAX - 2);

    logic [c_SW-1:0] r_stall_cnt;
    logic            w_same;

    assign w_same  = (lights_a_in == r_prev_a) && (lights_b_in == r_prev_b);
    // Trips on the repeat that makes STALL_MAX identical samples in a row.
    assign w_stall = (r_state == RUN) && w_same && (r_stall_cnt == c_STALL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state != RUN || w_trip) begin
            r_stall_cnt <= '0;
        end else if (sample_en) begin
            r_stall_cnt <= w_same ? r_stall_cnt + 1'b1 : '0;
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    // INIT has no baseline yet, so only stateless checks apply there.
    always_comb begin
        w_code = NONE;
        if (w_bad) begin
            w_code = BAD_CODE;
        end else if (w_conflict) begin
            w_code = CONFLICT;
        end else if (r_state == RUN) begin
            if (w_ill_a)       w_code = ILLEGAL_A;
            else if (w_ill_b)  w_code = ILLEGAL_B;
            else if (w_stall)  w_code = STALL;
        end
    end

    assign w_trip = sample_en && (w_code != NONE) &&
                    ((r_state == INIT) || (r_state == RUN));

    traffic_flash_gen #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flash (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_trip),
        .o_phase   (w_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= INIT;
            r_prev_a     <= RED;
            r_prev_b     <= RED;
            r_out_a      <= RED;
            r_out_b      <= RED;
            r_fault      <= 1'b0;
            r_fault_code <= NONE;
        end else begin
            case (r_state)
                INIT, RUN: begin
                    if (w_trip) begin
                        r_state      <= FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_code;
                        r_out_a      <= AMBER;
                        r_out_b      <= AMBER;
                    end else if (sample_en) begin
                        r_state  <= RUN;
                        r_prev_a <= lights_a_in;
                        r_prev_b <= lights_b_in;
                        r_out_a  <= lights_a_in;
                        r_out_b  <= lights_b_in;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        r_state      <= RECOVER;
                        r_fault      <= 1'b0;
                        r_fault_code <= NONE;
                        r_out_a      <= RED;
                        r_out_b      <= RED;
                    end else begin
                        r_out_a <= w_phase ? DARK : AMBER;
                        r_out_b <= w_phase ? DARK : AMBER;
                    end
                end
                RECOVER: begin
                    if (sample_en && lights_a_in == RED && lights_b_in == RED) begin
                        r_state  <= RUN;
                        r_prev_a <= RED;
                        r_prev_b <= RED;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign lights_a_out = r_out_a;
    assign lights_b_out = r_out_b;
    assign fault        = r_fault;
    assign fault_code   = r_fault_code;

endmodule

`default_nettype wire

// File: tb/tb_traffic_safety_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_traffic_safety_monitor                                                |
// | Directed self-checking bench for traffic_safety_monitor.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_traffic_safety_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic [2:0] lights_a_in = 3'b100;
    logic [2:0] lights_b_in = 3'b100;
    logic       clear_fault = 1'b0;
    logic [2:0] lights_a_out;
    logic [2:0] lights_b_out;
    logic       fault;
    logic [2:0] fault_code;

    int n_checks = 0;
    int n_fails  = 0;

    logic [2:0] seq_a [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b110, 3'b001, 3'b010, 3'b100};
    logic [2:0] seq_b [8] = '{3'b110, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};

    traffic_safety_monitor #(
        .FLASH_HALF (4),
        .STALL_MAX  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .lights_a_in  (lights_a_in),
        .lights_b_in  (lights_b_in),
        .clear_fault  (clear_fault),
        .lights_a_out (lights_a_out),
        .lights_b_out (lights_b_out),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {lights_a_out, lights_b_out, fault, fault_code};
    endfunction

    task automatic chk(input string tag, input logic [2:0] ea, input logic [2:0] eb,
                       input logic ef, input logic [2:0] ec);
        logic [9:0] o;
        logic [9:0] e;
        o = obs();
        e = {ea, eb, ef, ec};
        n_checks++;
        assert (o === e) else begin
            n_fails++;
            $error("FAIL %s: observed a/b/f/code=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                   tag, o[9:7], o[6:4], o[3], o[2:0], e[9:7], e[6:4], e[3], e[2:0]);
        end
    endtask

    // One clock with the given inputs; returns #1 after the edge.
    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic en, input logic clr);
        lights_a_in = a;
        lights_b_in = b;
        sample_en   = en;
        clear_fault = clr;
        @(posedge clk);
        #1;
        sample_en   = 1'b0;
        clear_fault = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_en = 1'b0;
        clear_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("reset", 3'b100, 3'b100, 1'b0, 3'd0);

        // Full sequencer cycle three times, forwarded with one cycle latency
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                cyc(seq_a[i], seq_b[i], 1'b1, 1'b0);
                chk($sformatf("fwd_r%0d_s%0d", r, i), seq_a[i], seq_b[i], 1'b0, 3'd0);
            end
        end

        // No sample_en: outputs hold even with garbage inputs
        cyc(3'b010, 3'b010, 1'b0, 1'b0);
        chk("hold_no_sample", 3'b100, 3'b100, 1'b0, 3'd0);

        // Conflict: enters FAULT with code 1, then flashes 4 amber / 4 dark
        cyc(3'b001, 3'b001, 1'b1, 1'b0);
        chk("conflict_entry", 3'b010, 3'b010, 1'b1, 3'd1);
        for (int k = 1; k < 12; k++) begin
            cyc(3'b001, 3'b001, 1'b1, 1'b0);
            chk($sformatf("flash_k%0d", k), ((k / 4) % 2 == 0) ? 3'b010 : 3'b000,
                ((k / 4) % 2 == 0) ? 3'b010 : 3'b000, 1'b1, 3'd1);
        end

        // Clear to RECOVER, then safe both-red re-entry
        cyc(3'b100, 3'b100, 1'b0, 1'b1);
        chk("clear_to_recover", 3'b100, 3'b100, 1'b0, 3'd0);
        cyc(3'b100, 3'b100, 1'b1, 1'b0);
        chk("recover_to_run", 3'b100, 3'b100, 1'b0, 3'd0);

        // Illegal step on A: code 2; later bad code on B does not overwrite it
        cyc(3'b001, 3'b100, 1'b1, 1'b0);
        chk("illegal_a", 3'b010, 3'b010, 1'b1, 3'd2);
        cyc(3'b100, 3'b111, 1'b1, 1'b0);
        chk("code_sticky", 3'b010, 3'b010, 1'b1, 3'd2);

        // Asynchronous reset between clock edges while in FAULT
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 3'b100, 3'b100, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bad code in INIT, clear, recovery gating, then forwarding resumes
        cyc(3'b100, 3'b011, 1'b1, 1'b0);
        chk("bad_code_init", 3'b010, 3'b010, 1'b1, 3'd4);
        cyc(3'b100, 3'b100, 1'b0, 1'b1);
        chk("clear2", 3'b100, 3'b100, 1'b0, 3'd0);
        cyc(3'b100, 3'b110, 1'b1, 1'b0);
        chk("recover_stays", 3'b100, 3'b100, 1'b0, 3'd0);
        cyc(3'b100, 3'b100, 1'b1, 1'b0);
        chk("recover_exit", 3'b100, 3'b100, 1'b0, 3'd0);
        cyc(3'b100, 3'b110, 1'b1, 1'b0);
        chk("fwd_after_recover", 3'b100, 3'b110, 1'b0, 3'd0);
        cyc(3'b100, 3'b001, 1'b1, 1'b1);
        chk("clear_ignored_run", 3'b100, 3'b001, 1'b0, 3'd0);

        // Fault and clear in the same RUN cycle: fault wins
        cyc(3'b001, 3'b001, 1'b1, 1'b1);
        chk("fault_beats_clear", 3'b010, 3'b010, 1'b1, 3'd1);

        // Stall watchdog: 16 identical 100/100 samples from a fresh reset
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            cyc(3'b100, 3'b100, 1'b1, 1'b0);
            if (i < 16) begin
                chk($sformatf("stall_hold_%0d", i), 3'b100, 3'b100, 1'b0, 3'd0);
            end else begin
`ifdef TRAFFIC_MON_WATCHDOG_EN
                chk("stall_trip", 3'b010, 3'b010, 1'b1, 3'd5);
`else
                chk("stall_absent", 3'b100, 3'b100, 1'b0, 3'd0);
`endif
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
